cdp_dp_chwin: RTL and testbench

CDP_DP_CHWIN -- requirements
Module: cdp_dp_chwin

---
 rtl/cdp_dp_chwin.sv | 211 +++++++++++++++++++++
 tb/tb_cdp_dp_chwin.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdp_dp_chwin.sv
// cdp_dp_chwin: cross-channel window former for the CDP datapath.
// Elements arrive one channel at a time and pass through a 9-deep shift
// register. Each channel yields one window of up to 9 neighbouring channels,
// zero padded at both ends of the pixel.
// Optional feature: define CDP_CHWIN_PERF_EN to add the dp2reg_win_stall
// output-stall counter.
// The element field is pd[DW-1:0], with DW at most 8.
// The flags sit at fixed pd bits 8/9/10.
module cdp_dp_chwin #(
  parameter int DW = 8
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic            cdp_rdma2dp_valid,
  output logic            cdp_rdma2dp_ready,
  input  logic [30:0]     cdp_rdma2dp_pd,
  input  logic [1:0]      reg2dp_normalz_len,
  input  logic            reg2dp_op_en,
  output logic            dp_win_valid,
  input  logic            dp_win_ready,
  output logic [9*DW-1:0] dp_win_pd,
  output logic            dp_win_pix_end,
  output logic            dp_win_layer_end
`ifdef CDP_CHWIN_PERF_EN
  ,
  output logic [31:0]     dp2reg_win_stall
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   sr_q [9];
  logic [DW-1:0]   sr_d [9];
  logic [2:0]      half_q, half_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      fc_q, fc_d;
  logic            le_q, le_d;
  logic            win_valid_q, win_valid_d;
  logic [9*DW-1:0] win_pd_q, win_pd_d;
  logic            pix_end_q, pix_end_d;
  logic            layer_end_q, layer_end_d;

  logic            out_free, accept, emit, last, flush_emit;
  logic [2:0]      fc_n;
  logic [3:0]      lo, hi;
  logic [9*DW-1:0] win;
  logic [DW-1:0]   in_data;
  logic            in_start, in_end, in_layer_end;
  logic            unused_pd;

  assign in_data      = cdp_rdma2dp_pd[DW-1:0];
  assign in_start     = cdp_rdma2dp_pd[8];
  assign in_end       = cdp_rdma2dp_pd[9];
  assign in_layer_end = cdp_rdma2dp_pd[10];
  assign unused_pd    = ^cdp_rdma2dp_pd[30:11];

  // Input handshake: RUN only back-pressures when the accept would emit into a full output register
  always_comb begin
    out_free          = !win_valid_q || dp_win_ready;
    cdp_rdma2dp_ready = 1'b0;
    if (nvdla_core_rstn && reg2dp_op_en) begin
      case (state_q)
        ST_IDLE:  cdp_rdma2dp_ready = 1'b1;
        ST_RUN:   cdp_rdma2dp_ready = (pend_q < half_q) || out_free;
        default:  cdp_rdma2dp_ready = 1'b0;
      endcase
    end
    accept = cdp_rdma2dp_valid && cdp_rdma2dp_ready;
  end

  // Next-state: shifting, pending count, flush sequencing and window/output-register load
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    half_d      = half_q;
    pend_d      = pend_q;
    fc_d        = fc_q;
    le_d        = le_q;
    win_valid_d = win_valid_q && !dp_win_ready;
    win_pd_d    = win_pd_q;
    pix_end_d   = pix_end_q;
    layer_end_d = layer_end_q;
    emit        = 1'b0;
    last        = 1'b0;
    flush_emit  = 1'b0;
    fc_n        = fc_q + 3'd1;
    win         = '0;
    lo          = 4'd0;
    hi          = 4'd0;
    if (!reg2dp_op_en) begin
      state_d     = ST_IDLE;
      pend_d      = 3'd0;
      win_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept && in_start) begin
            for (int i = 0; i < 8; i++) sr_d[i] = '0;
            sr_d[8] = in_data;
            half_d  = {1'b0, reg2dp_normalz_len} + 3'd1;
            pend_d  = 3'd1;
            fc_d    = 3'd0;
            state_d = ST_RUN;
            if (in_end) begin
              state_d = ST_FLUSH;
              le_d    = in_layer_end;
            end
          end else if (accept && state_q == ST_RUN) begin
            for (int i = 0; i < 8; i++) sr_d[i] = sr_q[i+1];
            sr_d[8] = in_data;
            if (pend_q == half_q) emit = 1'b1;
            else pend_d = pend_q + 3'd1;
            if (in_end) begin
              state_d = ST_FLUSH;
              le_d    = in_layer_end;
              fc_d    = 3'd0;
            end
          end
        end
        ST_FLUSH: begin
          flush_emit = fc_n > (half_q - pend_q);
          if (!flush_emit || out_free) begin
            for (int i = 0; i < 8; i++) sr_d[i] = sr_q[i+1];
            sr_d[8] = '0;
            fc_d    = fc_n;
            if (flush_emit) begin
              emit   = 1'b1;
              pend_d = pend_q - 3'd1;
            end
            if (fc_n == half_q) begin
              last    = 1'b1;
              state_d = ST_IDLE;
              fc_d    = 3'd0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    lo = 4'd4 - {1'b0, half_q};
    hi = 4'd4 + {1'b0, half_q};
    for (int k = 0; k < 9; k++) begin
      if (4'(k) >= lo && 4'(k) <= hi) win[k*DW +: DW] = sr_d[4'(k) + lo];
    end
    if (emit) begin
      win_valid_d = 1'b1;
      win_pd_d    = win;
      pix_end_d   = last;
      layer_end_d = last && le_q;
    end
  end

  // State, shift register and output register flops
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 9; i++) sr_q[i] <= '0;
      half_q      <= 3'd1;
      pend_q      <= 3'd0;
      fc_q        <= 3'd0;
      le_q        <= 1'b0;
      win_valid_q <= 1'b0;
      win_pd_q    <= '0;
      pix_end_q   <= 1'b0;
      layer_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      half_q      <= half_d;
      pend_q      <= pend_d;
      fc_q        <= fc_d;
      le_q        <= le_d;
      win_valid_q <= win_valid_d;
      win_pd_q    <= win_pd_d;
      pix_end_q   <= pix_end_d;
      layer_end_q <= layer_end_d;
    end
  end

  assign dp_win_valid     = win_valid_q;
  assign dp_win_pd        = win_pd_q;
  assign dp_win_pix_end   = pix_end_q;
  assign dp_win_layer_end = layer_end_q;

`ifdef CDP_CHWIN_PERF_EN
  logic        op_en_q;
  logic [31:0] stall_q, stall_d;

  // Stall counter: saturating count of blocked output cycles, cleared when the layer is re-enabled
  always_comb begin
    stall_d = stall_q;
    if (reg2dp_op_en && !op_en_q) stall_d = '0;
    else if (win_valid_q && !dp_win_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  // Stall counter and op_en edge-detect flops
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_q <= 1'b0;
      stall_q <= '0;
    end else begin
      op_en_q <= reg2dp_op_en;
      stall_q <= stall_d;
    end
  end

  assign dp2reg_win_stall = stall_q;
`endif

endmodule

// File: tb/tb_cdp_dp_chwin.sv
// Testbench for cdp_dp_chwin: drives pixels of random channels and compares
// every emitted window against a channel-neighbourhood reference model.
module tb_cdp_dp_chwin;

  typedef struct packed {
    logic [71:0] pd;
    logic        pe;
    logic        le;
  } win_t;

  logic        nvdla_core_clk;
  logic        nvdla_core_rstn;
  logic        cdp_rdma2dp_valid;
  logic        cdp_rdma2dp_ready;
  logic [30:0] cdp_rdma2dp_pd;
  logic [1:0]  reg2dp_normalz_len;
  logic        reg2dp_op_en;
  logic        dp_win_valid;
  logic        dp_win_ready;
  logic [71:0] dp_win_pd;
  logic        dp_win_pix_end;
  logic        dp_win_layer_end;
`ifdef CDP_CHWIN_PERF_EN
  logic [31:0] dp2reg_win_stall;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;
  bit   log_en = 0;
  logic [7:0] px [0:15];
  int   px_n = 0;
  win_t obs_q [$];
  win_t exp_q [$];
  bit   rl_exp [$];
  bit   rl_act [$];

  cdp_dp_chwin #(.DW(8)) dut (
    .nvdla_core_clk     (nvdla_core_clk),
    .nvdla_core_rstn    (nvdla_core_rstn),
    .cdp_rdma2dp_valid  (cdp_rdma2dp_valid),
    .cdp_rdma2dp_ready  (cdp_rdma2dp_ready),
    .cdp_rdma2dp_pd     (cdp_rdma2dp_pd),
    .reg2dp_normalz_len (reg2dp_normalz_len),
    .reg2dp_op_en       (reg2dp_op_en),
    .dp_win_valid       (dp_win_valid),
    .dp_win_ready       (dp_win_ready),
    .dp_win_pd          (dp_win_pd),
    .dp_win_pix_end     (dp_win_pix_end),
    .dp_win_layer_end   (dp_win_layer_end)
`ifdef CDP_CHWIN_PERF_EN
    ,
    .dp2reg_win_stall   (dp2reg_win_stall)
`endif
  );

  initial begin
    nvdla_core_clk = 1'b0;
    forever #5 nvdla_core_clk = ~nvdla_core_clk;
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 held low
  initial begin
    dp_win_ready = 1'b1;
    forever begin
      @(posedge nvdla_core_clk);
      #1;
      case (rdy_mode)
        0: dp_win_ready = 1'b1;
        1: dp_win_ready = ~dp_win_ready;
        2: dp_win_ready = 1'($urandom_range(1, 0));
        default: dp_win_ready = 1'b0;
      endcase
    end
  end

  // Collects each window handshake, sampled mid-cycle
  initial begin
    forever begin
      @(negedge nvdla_core_clk);
      if (nvdla_core_rstn && dp_win_valid && dp_win_ready)
        obs_q.push_back('{pd: dp_win_pd, pe: dp_win_pix_end, le: dp_win_layer_end});
    end
  end

  // Reference: window for channel c holds x[c+k-4] for |k-4| <= half, zero outside the pixel
  task automatic build_expected(input int code, input bit le);
    int h;
    int j;
    win_t w;
    h = code + 1;
    for (int c = 0; c < px_n; c++) begin
      w = '0;
      for (int k = 0; k < 9; k++) begin
        j = c + k - 4;
        if (k - 4 <= h && 4 - k <= h && j >= 0 && j < px_n) w.pd[k*8 +: 8] = px[j];
      end
      w.pe = (c == px_n - 1);
      w.le = le && w.pe;
      exp_q.push_back(w);
    end
  endtask

  // Sends px[0..px_n-1] as one pixel; call at posedge+1, returns at posedge+1 after the last accept
  task automatic send_pixel(input int code, input bit le, input int gap_max);
    int acc;
    int guard;
    int h;
    h = code + 1;
    acc = 0;
    reg2dp_normalz_len = 2'(code);
    while (acc < px_n) begin
      repeat ($urandom_range(gap_max, 0)) begin
        cdp_rdma2dp_valid = 1'b0;
        @(posedge nvdla_core_clk);
        #1;
      end
      cdp_rdma2dp_valid = 1'b1;
      cdp_rdma2dp_pd = {20'h0, le && (acc == px_n - 1), acc == px_n - 1, acc == 0, px[acc]};
      guard = 0;
      forever begin
        @(negedge nvdla_core_clk);
        if (log_en && acc > 0) begin
          rl_exp.push_back(!(acc >= h && dp_win_valid && !dp_win_ready));
          rl_act.push_back(cdp_rdma2dp_ready);
        end
        if (cdp_rdma2dp_ready) break;
        guard++;
        if (guard > 300) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL input_accept_timeout: got ready=0 for 300 cycles, expected an accept");
          break;
        end
      end
      @(posedge nvdla_core_clk);
      #1;
      acc++;
    end
    cdp_rdma2dp_valid = 1'b0;
  endtask

  // Waits (bounded) for the expected windows to appear, plus some margin for extras
  task automatic drain();
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 500) begin
      @(posedge nvdla_core_clk);
      #1;
      t++;
    end
    repeat (10) @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    px_n = n;
    for (int i = 0; i < n; i++) px[i] = 8'($urandom_range(255, 1));
  endtask

  task automatic test_reset();
    nvdla_core_rstn = 1'b0;
    #2;
    n_cmp += 5;
    if (cdp_rdma2dp_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", cdp_rdma2dp_ready); end
    if (dp_win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", dp_win_valid); end
    if (dp_win_pd !== 72'h0) begin n_bad++; $display("[TB] FAIL reset_pd: got %h expected 0", dp_win_pd); end
    if (dp_win_pix_end !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pix_end: got %b expected 0", dp_win_pix_end); end
    if (dp_win_layer_end !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_layer_end: got %b expected 0", dp_win_layer_end); end
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (cdp_rdma2dp_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL idle_in_ready: got %b expected 1", cdp_rdma2dp_ready); end
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    px_n = 4;
    px[0] = 8'd1; px[1] = 8'd2; px[2] = 8'd3; px[3] = 8'd4;
    build_expected(1, 1'b0);
    send_pixel(1, 1'b0, 0);
    drain();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL basic_win%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single();
    rdy_mode = 0;
    px_n = 1;
    px[0] = 8'd5;
    build_expected(3, 1'b0);
    send_pixel(3, 1'b0, 0);
    drain();
    n_cmp++;
    if (obs_q.size() != 1) begin n_bad++; $display("[TB] FAIL single_count: got %0d expected 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL single_win: got %h expected %h", obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_toggle();
    rdy_mode = 1;
    log_en = 1'b1;
    fill_random(8);
    build_expected(0, 1'b0);
    send_pixel(0, 1'b0, 0);
    log_en = 1'b0;
    drain();
    rdy_mode = 0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL toggle_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL toggle_win%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < rl_exp.size(); i++) begin
      n_cmp++;
      if (rl_act[i] !== rl_exp[i]) begin n_bad++; $display("[TB] FAIL toggle_in_ready%0d: got %b expected %b", i, rl_act[i], rl_exp[i]); end
    end
    obs_q.delete(); exp_q.delete(); rl_exp.delete(); rl_act.delete();
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    rdy_mode = 0;
    c1 = $urandom_range(3, 0);
    c2 = $urandom_range(3, 0);
    fill_random(5);
    build_expected(c1, 1'b0);
    send_pixel(c1, 1'b0, 0);
    fill_random(3);
    build_expected(c2, 1'b1);
    send_pixel(c2, 1'b1, 0);
    drain();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL b2b_win%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int code;
    bit le;
    rdy_mode = 2;
    for (int p = 0; p < 8; p++) begin
      code = $urandom_range(3, 0);
      le = 1'($urandom_range(1, 0));
      fill_random($urandom_range(8, 1));
      build_expected(code, le);
      send_pixel(code, le, 2);
    end
    drain();
    rdy_mode = 0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL rand_win%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_op_en();
    rdy_mode = 3;
    px_n = 2;
    px[0] = 8'd3; px[1] = 8'd4;
    send_pixel(0, 1'b0, 0);
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    reg2dp_op_en = 1'b0;
    #1;
    n_cmp++;
    if (cdp_rdma2dp_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL opoff_in_ready: got %b expected 0", cdp_rdma2dp_ready); end
    @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (dp_win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL opoff_valid: got %b expected 0", dp_win_valid); end
    reg2dp_op_en = 1'b1;
    rdy_mode = 0;
    obs_q.delete(); exp_q.delete();
    repeat (8) @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("[TB] FAIL opoff_no_window: got %0d windows expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_flush();
    int code;
    rdy_mode = 0;
    fill_random(6);
    send_pixel(3, 1'b1, 0);
    @(posedge nvdla_core_clk);
    #3;
    nvdla_core_rstn = 1'b0;
    #1;
    n_cmp += 3;
    if (dp_win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rstflush_valid: got %b expected 0", dp_win_valid); end
    if (dp_win_pd !== 72'h0) begin n_bad++; $display("[TB] FAIL rstflush_pd: got %h expected 0", dp_win_pd); end
    if (cdp_rdma2dp_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rstflush_in_ready: got %b expected 0", cdp_rdma2dp_ready); end
    obs_q.delete(); exp_q.delete();
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
    repeat (8) @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("[TB] FAIL rstflush_no_window: got %0d windows expected 0", obs_q.size()); end
    code = $urandom_range(3, 0);
    px_n = 1;
    px[0] = 8'd7;
    build_expected(code, 1'b0);
    send_pixel(code, 1'b0, 0);
    drain();
    n_cmp++;
    if (obs_q.size() != 1) begin n_bad++; $display("[TB] FAIL rstflush_count: got %0d expected 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL rstflush_win: got %h expected %h", obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef CDP_CHWIN_PERF_EN
  task automatic test_perf();
    int t;
    reg2dp_op_en = 1'b0;
    @(posedge nvdla_core_clk);
    #1;
    reg2dp_op_en = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (dp2reg_win_stall !== 32'd0) begin n_bad++; $display("[TB] FAIL perf_clear0: got %0d expected 0", dp2reg_win_stall); end
    rdy_mode = 3;
    px_n = 1;
    px[0] = 8'd9;
    build_expected(0, 1'b0);
    send_pixel(0, 1'b0, 0);
    t = 0;
    while (!dp_win_valid && t < 20) begin
      @(negedge nvdla_core_clk);
      t++;
    end
    repeat (10) @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (dp2reg_win_stall !== 32'd10) begin n_bad++; $display("[TB] FAIL perf_stall: got %0d expected 10", dp2reg_win_stall); end
    rdy_mode = 0;
    drain();
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_bad++; $display("[TB] FAIL perf_win: got %0d windows expected 1 matching"); end
    obs_q.delete(); exp_q.delete();
    reg2dp_op_en = 1'b0;
    @(posedge nvdla_core_clk);
    #1;
    reg2dp_op_en = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    n_cmp++;
    if (dp2reg_win_stall !== 32'd0) begin n_bad++; $display("[TB] FAIL perf_clear: got %0d expected 0", dp2reg_win_stall); end
  endtask
`endif

  initial begin
    nvdla_core_rstn    = 1'b0;
    cdp_rdma2dp_valid  = 1'b0;
    cdp_rdma2dp_pd     = '0;
    reg2dp_normalz_len = 2'd0;
    reg2dp_op_en       = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_toggle();
    test_back_to_back();
    test_random();
    test_op_en();
    test_reset_flush();
`ifdef CDP_CHWIN_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
